// File: rtl/ped_request_ctrl.sv
// Pedestrian request front-end: synchronises and debounces the button, issues a one-cycle Set once
// Green has aged enough, and follows lamp feedback for Wait/Walk. Every output is a flop.
module ped_request_ctrl #(
   parameter int num_of_bit   = 4,
   parameter int debounce_len = 3,
   parameter int min_green    = 5,
   parameter int cooldown     = 8
) (
   input  logic CLK,
   input  logic Reset,
   input  logic Button,
   input  logic Red,
   input  logic Yellow,
   input  logic Green,
   output logic Set,
   output logic Wait_lamp,
   output logic Walk,
   output logic Fault
);

   typedef logic [num_of_bit-1:0] cnt_t;

   localparam cnt_t DB_LAST  = cnt_t'(debounce_len - 1);
   localparam cnt_t MIN_AGE  = cnt_t'(min_green);
   localparam cnt_t COOL_LEN = cnt_t'(cooldown);
   localparam cnt_t CNT_MAX  = '1;
   localparam cnt_t CNT_ONE  = cnt_t'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PENDING,
      S_SET_PULSE,
      S_WAIT_RED,
      S_WALK,
      S_COOLDOWN
   } state_t;

   logic   r_sync1;
   logic   r_sync2;
   logic   r_stable;
   cnt_t   r_db_cnt;
   logic   r_press;
   cnt_t   r_age;
   logic   r_fault;
   state_t r_state;
   cnt_t   r_cd;
   logic   r_sticky;
   logic   r_set;
   logic   r_wait;
   logic   r_walk;

   logic   w_lamps_ok;
   logic   w_green;
   logic   w_red;
   logic   w_aged;

   // One-hot check: odd parity rules out 0 and 2 lamps, the AND term rules out all 3.
   assign w_lamps_ok = (Red ^ Yellow ^ Green) & ~(Red & Yellow & Green);
   assign w_green    = Green & w_lamps_ok;
   assign w_red      = Red & w_lamps_ok;

   if (min_green == 0) begin : g_no_min_green
      assign w_aged = 1'b1;
   end else begin : g_min_green
      assign w_aged = (r_age >= MIN_AGE);
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= Button;
         r_sync2 <= r_sync1;
      end
   end

   // The new level is taken on the debounce_len-th consecutive differing sample.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_stable <= 1'b0;
         r_db_cnt <= '0;
         r_press  <= 1'b0;
      end else if (r_sync2 != r_stable) begin
         if (r_db_cnt == DB_LAST) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
            r_press  <= r_sync2;
         end else begin
            r_db_cnt <= r_db_cnt + CNT_ONE;
            r_press  <= 1'b0;
         end
      end else begin
         r_db_cnt <= '0;
         r_press  <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_age   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_fault <= ~w_lamps_ok;
         if (!w_green) begin
            r_age <= '0;
         end else if (r_age != CNT_MAX) begin
            r_age <= r_age + CNT_ONE;
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state  <= S_IDLE;
         r_cd     <= '0;
         r_sticky <= 1'b0;
         r_set    <= 1'b0;
         r_wait   <= 1'b0;
         r_walk   <= 1'b0;
      end else begin
         r_set <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_press) begin
                  r_state <= S_PENDING;
                  r_wait  <= 1'b1;
               end
            end
            S_PENDING: begin
               if (w_green && w_aged) begin
                  r_state <= S_SET_PULSE;
                  r_set   <= 1'b1;
               end
            end
            S_SET_PULSE: begin
               r_state <= S_WAIT_RED;
            end
            S_WAIT_RED: begin
               if (w_red) begin
                  r_state <= S_WALK;
                  r_wait  <= 1'b0;
                  r_walk  <= 1'b1;
               end
            end
            S_WALK: begin
               if (!w_red) begin
                  r_state <= S_COOLDOWN;
                  r_walk  <= 1'b0;
                  r_cd    <= COOL_LEN;
               end
            end
            S_COOLDOWN: begin
               // A press landing on the exit cycle is honoured like an earlier sticky one.
               if (r_cd == CNT_ONE) begin
                  r_sticky <= 1'b0;
                  if (r_sticky || r_press) begin
                     r_state <= S_PENDING;
                     r_wait  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cd <= r_cd - CNT_ONE;
                  if (r_press) begin
                     r_sticky <= 1'b1;
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_wait   <= 1'b0;
               r_walk   <= 1'b0;
               r_sticky <= 1'b0;
            end
         endcase
      end
   end

   assign Set       = r_set;
   assign Wait_lamp = r_wait;
   assign Walk      = r_walk;
   assign Fault     = r_fault;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Two instances (default timing and a min_green=0 / cooldown=1 corner) are checked every cycle
// against a timestamp/history model, plus hand-derived checks on the default instance.
module tb_ped_request_ctrl;

   localparam int NI = 2;
   localparam int P_IDLE = 0, P_PEND = 1, P_SET = 2, P_WRED = 3, P_WALK = 4, P_COOL = 5;

   logic CLK = 1'b0;
   logic Reset = 1'b1;
   logic Button = 1'b0;
   logic Red = 1'b1, Yellow = 1'b0, Green = 1'b0;
   logic [NI-1:0] set_o, wait_o, walk_o, fault_o;

   int n_checks = 0;
   int n_fail = 0;
   bit run_cmp = 1'b0;

   int cfg_db[NI] = '{3, 2};
   int cfg_mg[NI] = '{5, 0};
   int cfg_cd[NI] = '{8, 1};

   int m_phase[NI];
   int m_gstart[NI] = '{-1, -1};
   int m_cool_end[NI];
   int m_hist[NI];
   bit m_sticky[NI], m_s1[NI], m_s2[NI], m_stable[NI], m_press[NI];
   bit e_set[NI], e_wait[NI], e_walk[NI], e_fault[NI];
   int m_cyc = 0;
   bit mo_ok, mo_g, mo_r;

   ped_request_ctrl #(.num_of_bit(4), .debounce_len(3), .min_green(5), .cooldown(8)) u0 (
      .CLK(CLK), .Reset(Reset), .Button(Button), .Red(Red), .Yellow(Yellow), .Green(Green),
      .Set(set_o[0]), .Wait_lamp(wait_o[0]), .Walk(walk_o[0]), .Fault(fault_o[0]));

   ped_request_ctrl #(.num_of_bit(4), .debounce_len(2), .min_green(0), .cooldown(1)) u1 (
      .CLK(CLK), .Reset(Reset), .Button(Button), .Red(Red), .Yellow(Yellow), .Green(Green),
      .Set(set_o[1]), .Wait_lamp(wait_o[1]), .Walk(walk_o[1]), .Fault(fault_o[1]));

   always #5 CLK = ~CLK;

   task automatic check(string name, int idx, logic got, logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s u%0d: got %b, expected %b at %0t", name, idx, got, exp, $time);
      end
   endtask

   function automatic void model_reset(int i);
      m_phase[i] = P_IDLE;  m_gstart[i] = -1; m_cool_end[i] = 0; m_hist[i] = 0;
      m_sticky[i] = 1'b0;   m_s1[i] = 1'b0;   m_s2[i] = 1'b0;
      m_stable[i] = 1'b0;   m_press[i] = 1'b0;
      e_set[i] = 1'b0; e_wait[i] = 1'b0; e_walk[i] = 1'b0; e_fault[i] = 1'b0;
   endfunction

   // One clock edge of behaviour; c is the index of the cycle that just ended.
   function automatic void model_step(int i, int c);
      bit pr;
      int age, mask;
      pr = m_press[i];
      if (m_gstart[i] < 0) age = 0;
      else age = (c - m_gstart[i] > 15) ? 15 : c - m_gstart[i];
      case (m_phase[i])
         P_IDLE: if (pr) m_phase[i] = P_PEND;
         P_PEND: if (mo_g && age >= cfg_mg[i]) m_phase[i] = P_SET;
         P_SET:  m_phase[i] = P_WRED;
         P_WRED: if (mo_r) m_phase[i] = P_WALK;
         P_WALK: if (!mo_r) begin
            m_phase[i] = P_COOL;
            m_cool_end[i] = c + cfg_cd[i];
         end
         default: begin
            if (pr) m_sticky[i] = 1'b1;
            if (c == m_cool_end[i]) begin
               m_phase[i] = m_sticky[i] ? P_PEND : P_IDLE;
               m_sticky[i] = 1'b0;
            end
         end
      endcase
      if (mo_g) begin
         if (m_gstart[i] < 0) m_gstart[i] = c;
      end else begin
         m_gstart[i] = -1;
      end
      mask = (1 << cfg_db[i]) - 1;
      m_hist[i] = ((m_hist[i] << 1) | int'(m_s2[i])) & 32'hFFFF;
      m_press[i] = 1'b0;
      if ((m_hist[i] & mask) == (m_stable[i] ? 0 : mask)) begin
         m_stable[i] = !m_stable[i];
         m_press[i] = m_stable[i];
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = Button;
      e_set[i]   = (m_phase[i] == P_SET);
      e_wait[i]  = (m_phase[i] == P_PEND) || (m_phase[i] == P_SET) || (m_phase[i] == P_WRED);
      e_walk[i]  = (m_phase[i] == P_WALK);
      e_fault[i] = !mo_ok;
   endfunction

   always @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         m_cyc = 0;
         for (int i = 0; i < NI; i++) model_reset(i);
      end else begin
         mo_ok = (int'(Red) + int'(Yellow) + int'(Green)) == 1;
         mo_g  = Green && mo_ok;
         mo_r  = Red && mo_ok;
         for (int i = 0; i < NI; i++) model_step(i, m_cyc);
         m_cyc++;
      end
   end

   always @(negedge CLK) begin
      if (run_cmp) begin
         for (int i = 0; i < NI; i++) begin
            check("Set", i, set_o[i], e_set[i]);
            check("Wait_lamp", i, wait_o[i], e_wait[i]);
            check("Walk", i, walk_o[i], e_walk[i]);
            check("Fault", i, fault_o[i], e_fault[i]);
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic lamps(bit r, bit y, bit g);
      Red = r; Yellow = y; Green = g;
   endtask

   initial begin
      int lamp_left, lamp_ph, btn_left;
      #1 Reset = 1'b0;
      #1 run_cmp = 1'b1;
      #11;
      check("rst_set", 0, set_o[0], 1'b0);
      check("rst_wait", 0, wait_o[0], 1'b0);
      check("rst_walk", 0, walk_o[0], 1'b0);
      check("rst_fault", 0, fault_o[0], 1'b0);
      #10 Reset = 1'b1;
      cyc(3);

      // Bounce 1-0-1-0, then a clean 10-cycle hold while Red is lit.
      Button = 1'b1; cyc(1); Button = 1'b0; cyc(1);
      Button = 1'b1; cyc(1); Button = 1'b0; cyc(1);
      Button = 1'b1;
      cyc(5); check("wait_before_press", 0, wait_o[0], 1'b0);
      cyc(1); check("wait_after_press", 0, wait_o[0], 1'b1);
      cyc(4); Button = 1'b0;

      // Green from now: Set appears after six green edges, for one cycle.
      lamps(0, 0, 1);
      cyc(5); check("set_early", 0, set_o[0], 1'b0);
      cyc(1); check("set_pulse", 0, set_o[0], 1'b1);
      cyc(1); check("set_after", 0, set_o[0], 1'b0);
      check("wait_in_wait_red", 0, wait_o[0], 1'b1);

      lamps(0, 1, 0); cyc(3);
      lamps(1, 0, 0);
      cyc(1); check("walk_on_red", 0, walk_o[0], 1'b1);
      cyc(3); Button = 1'b1;
      cyc(2); check("walk_whole_red", 0, walk_o[0], 1'b1);
      lamps(0, 0, 1);
      cyc(1); check("walk_drop", 0, walk_o[0], 1'b0);
      cyc(7); check("cooldown_no_wait", 0, wait_o[0], 1'b0);
      check("cooldown_no_set", 0, set_o[0], 1'b0);
      Button = 1'b0;
      cyc(1); check("sticky_pending", 0, wait_o[0], 1'b1);
      cyc(1); check("sticky_set", 0, set_o[0], 1'b1);

      // Red and Green together while waiting for Red.
      cyc(1); lamps(1, 0, 1);
      cyc(1); check("fault_1", 0, fault_o[0], 1'b1);
      check("no_walk_fault_1", 0, walk_o[0], 1'b0);
      cyc(1); check("fault_2", 0, fault_o[0], 1'b1);
      check("no_walk_fault_2", 0, walk_o[0], 1'b0);
      lamps(1, 0, 0);
      cyc(1); check("fault_clear", 0, fault_o[0], 1'b0);
      check("walk_valid_red", 0, walk_o[0], 1'b1);

      // Asynchronous reset in the middle of the walk.
      #1 Reset = 1'b0;
      #1 check("async_rst_walk", 0, walk_o[0], 1'b0);
      check("async_rst_wait", 0, wait_o[0], 1'b0);
      check("async_rst_set", 0, set_o[0], 1'b0);
      #3 Reset = 1'b1;
      cyc(2); check("idle_after_rst", 0, walk_o[0], 1'b0);
      check("idle_after_rst_wait", 0, wait_o[0], 1'b0);

      // Randomised traffic: lamp cycle with occasional bad lamp patterns, bouncy button.
      lamp_left = 0; lamp_ph = 2; btn_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if (lamp_left == 0) begin
            if ($urandom_range(0, 29) == 0) begin
               {Red, Yellow, Green} = 3'($urandom_range(0, 7));
               lamp_left = $urandom_range(1, 3);
            end else begin
               lamp_ph = (lamp_ph + 1) % 3;
               lamps(lamp_ph == 2, lamp_ph == 1, lamp_ph == 0);
               lamp_left = $urandom_range(1, 14);
            end
         end
         lamp_left--;
         if (btn_left == 0) begin
            Button = 1'($urandom_range(0, 1));
            btn_left = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 12) : $urandom_range(1, 2);
         end
         btn_left--;
         cyc(1);
      end

      run_cmp = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
